// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sequencer: instruction encoding, field
// offsets and the controller state enum.
package glitch_pkg;

    localparam logic [1:0] I2C_CHK  = 2'b00;
    localparam logic [1:0] DAC_UP   = 2'b01;
    localparam logic [1:0] DELAY    = 2'b10;

    localparam logic       PRIV_BUS = 1'b0;
    localparam logic       MAIN_BUS = 1'b1;

    localparam logic       ACK      = 1'b0;
    localparam logic       NAK      = 1'b1;

    localparam int OP_MSB   = 11;
    localparam int OP_LSB   = 10;
    localparam int BUS_BIT  = 9;
    localparam int DATA_MSB = 8;
    localparam int DATA_LSB = 1;
    localparam int ACK_BIT  = 0;

    typedef struct packed {
        logic [1:0] op;
        logic       bus;
        logic [7:0] data;
        logic       ack;
    } instr_t;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        FETCH      = 4'd1,
        DISPATCH   = 4'd2,
        EXEC_I2C   = 4'd3,
        EXEC_DAC   = 4'd4,
        EXEC_DELAY = 4'd5,
        ADVANCE    = 4'd6,
        DONE       = 4'd7,
        ERROR      = 4'd8
    } state_e;

endpackage

// File: rtl/glitch_delay_ctr.sv
// 32-bit down-counter timing the EXEC_DELAY state; expired is high on the
// last cycle of a max(len,1)-cycle wait that starts the cycle after load.
module glitch_delay_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] len,
    output logic        expired
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Reload on entry, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = len;
        end else if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A length of 0 or 1 both give a single-cycle wait
    assign expired = (cnt_q <= 32'd1);

endmodule

// File: rtl/glitch_sequencer.sv
// ROM-driven sequencer issuing DAC writes, I2C checks and delays.
// Optional GLITCH_SEQ_ABORT_EN adds an abort input that cancels a run.
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int PROG_LEN = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  instr_pt,
    input  logic [11:0] instr,
    output logic [7:0]  delay_num,
    input  logic [31:0] delay_len,
    output logic [7:0]  dac_data,
    output logic        dac_valid,
    input  logic        dac_ready,
    output logic        i2c_req,
    output logic        i2c_bus,
    output logic [7:0]  i2c_byte,
    output logic        i2c_expect_nak,
    input  logic        i2c_done,
    input  logic        i2c_nak,
    output logic        busy,
    output logic        done,
    output logic        error
`ifdef GLITCH_SEQ_ABORT_EN
    ,
    input  logic        abort
`endif
);

    localparam logic [7:0] PROG_LEN_C = 8'(PROG_LEN);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    instr_t     ir_q, ir_d;
    logic       error_q, error_d;
    logic       ctr_load_s;
    logic       ctr_expired_s;

    glitch_delay_ctr u_delay_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ctr_load_s),
        .len     (delay_len),
        .expired (ctr_expired_s)
    );

    // Next-state, program counter, instruction register and sticky error
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        error_d    = error_q;
        ctr_load_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = 8'd0;
                    error_d = 1'b0;
                    state_d = (PROG_LEN_C == 8'd0) ? DONE : FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                ir_d    = instr_t'(instr);
                state_d = DISPATCH;
            end
            DISPATCH: begin
                case (ir_q.op)
                    I2C_CHK: state_d = EXEC_I2C;
                    DAC_UP:  state_d = EXEC_DAC;
                    DELAY: begin
                        ctr_load_s = 1'b1;
                        state_d    = EXEC_DELAY;
                    end
                    default: begin
                        error_d = 1'b1;
                        state_d = ERROR;
                    end
                endcase
            end
            EXEC_I2C: begin
                if (!i2c_done) begin
                    state_d = EXEC_I2C;
                end else if (i2c_nak == ir_q.ack) begin
                    state_d = ADVANCE;
                end else begin
                    error_d = 1'b1;
                    state_d = ERROR;
                end
            end
            EXEC_DAC: begin
                if (dac_ready) begin
                    state_d = ADVANCE;
                end else begin
                    state_d = EXEC_DAC;
                end
            end
            EXEC_DELAY: begin
                if (ctr_expired_s) begin
                    state_d = ADVANCE;
                end else begin
                    state_d = EXEC_DELAY;
                end
            end
            ADVANCE: begin
                pc_d    = pc_q + 8'd1;
                state_d = (pc_d == PROG_LEN_C) ? DONE : FETCH;
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef GLITCH_SEQ_ABORT_EN
        // Abort wins over any handshake or expiry seen in the same cycle
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            pc_d       = pc_q;
            ir_d       = ir_q;
            error_d    = 1'b1;
            ctr_load_s = 1'b0;
        end else begin
            state_d = state_d;
        end
`endif
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= 8'd0;
            ir_q    <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            error_q <= error_d;
        end
    end

    // Outputs decode only registered state, so reset zeroes them at once
    assign instr_pt       = pc_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign error          = error_q;
    assign dac_valid      = (state_q == EXEC_DAC);
    assign dac_data       = dac_valid ? ir_q.data : 8'd0;
    assign i2c_req        = (state_q == EXEC_I2C);
    assign i2c_bus        = i2c_req ? ir_q.bus : 1'b0;
    assign i2c_byte       = i2c_req ? ir_q.data : 8'd0;
    assign i2c_expect_nak = i2c_req ? ir_q.ack : 1'b0;
    assign delay_num      = ((state_q == DISPATCH) || (state_q == EXEC_DELAY)) ? ir_q.data : 8'd0;

endmodule
